// File: rtl/cap_ctrl_pkg.sv
// Shared state encoding and default geometry for the dahua_cap frame sequencer.
package cap_ctrl_pkg;

  localparam int DEF_WIDTH       = 640;
  localparam int DEF_HEIGTH      = 480;
  localparam int DEF_TIMEOUT_CYC = 2**24;
  localparam int DEF_NF_W        = 8;

  typedef logic [2:0] cap_state_t;

  localparam cap_state_t ST_IDLE     = 3'd0;
  localparam cap_state_t ST_ARM      = 3'd1;
  localparam cap_state_t ST_WAIT_SOF = 3'd2;
  localparam cap_state_t ST_CAPTURE  = 3'd3;
  localparam cap_state_t ST_SKIP     = 3'd4;
  localparam cap_state_t ST_DONE     = 3'd5;
  localparam cap_state_t ST_ERROR    = 3'd6;

  // States in which the sensor is expected to keep toggling FV.
  function automatic logic wd_counts(input cap_state_t s);
    return (s == ST_ARM) || (s == ST_WAIT_SOF) || (s == ST_SKIP) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/cap_ctrl_geom_chk.sv
// Per-frame line length / line count checker; pulses size_err at eof of a bad frame.
module cap_geom_chk
  import cap_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGTH = DEF_HEIGTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic win,
  input  logic sof,
  input  logic eof,
  input  logic eol,
  input  logic lv,
  output logic size_err
);

  localparam int PX_W = $clog2(WIDTH + 1);
  localparam int LN_W = $clog2(HEIGTH + 1);

  logic [PX_W-1:0] px_q, px_d;
  logic [LN_W-1:0] ln_q, ln_d;
  logic            bad_q, bad_d;

  // A short or long line is remembered until eof so one report covers the whole frame.
  always_comb begin
    px_d     = px_q;
    ln_d     = ln_q;
    bad_d    = bad_q;
    size_err = 1'b0;
    if (win) begin
      if (sof) begin
        px_d  = PX_W'(lv);
        ln_d  = '0;
        bad_d = 1'b0;
      end else if (eol) begin
        if (px_q != PX_W'(WIDTH)) bad_d = 1'b1;
        px_d = '0;
        if (ln_q != '1) ln_d = ln_q + 1'b1;
      end else if (lv && (px_q != '1)) begin
        px_d = px_q + 1'b1;
      end
      if (eof) size_err = bad_d | (ln_d != LN_W'(HEIGTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q  <= '0;
      ln_q  <= '0;
      bad_q <= 1'b0;
    end else begin
      px_q  <= px_d;
      ln_q  <= ln_d;
      bad_q <= bad_d;
    end
  end

endmodule

// File: rtl/cap_ctrl.sv
// Frame-level capture sequencer: gates cap_en over whole frames only, with
// N-frame/continuous modes, frame decimation, FV watchdog and geometry check.
module cap_ctrl
  import cap_ctrl_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGTH      = DEF_HEIGTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int NF_W        = DEF_NF_W
) (
  input  logic            pclk,
  input  logic            resetn,
  input  logic            FV,
  input  logic            LV,
  input  logic            cmd_start,
  input  logic            cmd_stop,
  input  logic [NF_W-1:0] cfg_nframes,
  input  logic [NF_W-1:0] cfg_skip,
  output logic            cap_en,
  output logic            busy,
  output logic            done,
  output logic [NF_W-1:0] frame_cnt,
  output logic            err_size,
  output logic            err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  cap_state_t      state_q, state_d;
  logic            fv_q, fv_d, lv_q, lv_d;
  logic [NF_W-1:0] frame_cnt_q, frame_cnt_d, frame_inc;
  logic [NF_W-1:0] nframes_q, nframes_d, skip_q, skip_d, skip_cnt_q, skip_cnt_d;
  logic            err_size_q, err_size_d, err_timeout_q, err_timeout_d;
  logic            stop_pend_q, stop_pend_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            sof, eof, eol, timeout, start_acc, geom_win, size_err;

  assign sof       = FV & ~fv_q;
  assign eof       = ~FV & fv_q;
  assign eol       = ~LV & lv_q;
  assign timeout   = wd_counts(state_q) & ~(sof | eof) & (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign start_acc = cmd_start & ~cmd_stop & ((state_q == ST_IDLE) || (state_q == ST_ERROR));
  assign geom_win  = (state_q == ST_CAPTURE) || ((state_q == ST_WAIT_SOF) && sof);
  assign frame_inc = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + 1'b1;

  // cap_en mirrors FV over captured frames: it is already low in the eof cycle.
  assign cap_en      = ~timeout & (((state_q == ST_CAPTURE) & ~eof) | ((state_q == ST_WAIT_SOF) & sof));
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign done        = (state_q == ST_DONE);
  assign frame_cnt   = frame_cnt_q;
  assign err_size    = err_size_q;
  assign err_timeout = err_timeout_q;

  cap_geom_chk #(.WIDTH(WIDTH), .HEIGTH(HEIGTH)) u_geom (
    .clk      (pclk),
    .rst_n    (resetn),
    .win      (geom_win),
    .sof      (sof),
    .eof      (eof),
    .eol      (eol),
    .lv       (LV),
    .size_err (size_err)
  );

  always_comb begin
    state_d       = state_q;
    fv_d          = FV;
    lv_d          = LV;
    frame_cnt_d   = frame_cnt_q;
    nframes_d     = nframes_q;
    skip_d        = skip_q;
    skip_cnt_d    = skip_cnt_q;
    err_size_d    = err_size_q;
    err_timeout_d = err_timeout_q;
    stop_pend_d   = stop_pend_q;
    case (state_q)
      ST_ARM: begin
        if (cmd_stop) state_d = ST_DONE;
        else if (!FV) state_d = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (cmd_stop) state_d = ST_DONE;
        else if (sof) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (cmd_stop) stop_pend_d = 1'b1;
        if (eof) begin
          frame_cnt_d = frame_inc;
          if (size_err) err_size_d = 1'b1;
          if (stop_pend_q || cmd_stop) begin
            state_d = ST_DONE;
          end else if ((nframes_q != '0) && (frame_inc == nframes_q)) begin
            state_d = ST_DONE;
          end else if (skip_q != '0) begin
            state_d    = ST_SKIP;
            skip_cnt_d = skip_q;
          end else begin
            state_d = ST_WAIT_SOF;
          end
        end
      end
      ST_SKIP: begin
        if (cmd_stop) begin
          state_d = ST_DONE;
        end else if (eof) begin
          skip_cnt_d = skip_cnt_q - 1'b1;
          if (skip_cnt_d == '0) state_d = ST_WAIT_SOF;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: if (cmd_stop) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (timeout) begin
      state_d       = ST_ERROR;
      err_timeout_d = 1'b1;
    end
    if (start_acc) begin
      state_d       = ST_ARM;
      frame_cnt_d   = '0;
      err_size_d    = 1'b0;
      err_timeout_d = 1'b0;
      nframes_d     = cfg_nframes;
      skip_d        = cfg_skip;
    end
    if (state_d != ST_CAPTURE) stop_pend_d = 1'b0;
  end

  // Watchdog restarts on every FV edge and on every state transition.
  assign wd_d = (!wd_counts(state_q) || sof || eof || (state_d != state_q)) ? '0 : wd_q + 1'b1;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      fv_q          <= 1'b0;
      lv_q          <= 1'b0;
      frame_cnt_q   <= '0;
      nframes_q     <= '0;
      skip_q        <= '0;
      skip_cnt_q    <= '0;
      err_size_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      stop_pend_q   <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      fv_q          <= fv_d;
      lv_q          <= lv_d;
      frame_cnt_q   <= frame_cnt_d;
      nframes_q     <= nframes_d;
      skip_q        <= skip_d;
      skip_cnt_q    <= skip_cnt_d;
      err_size_q    <= err_size_d;
      err_timeout_q <= err_timeout_d;
      stop_pend_q   <= stop_pend_d;
      wd_q          <= wd_d;
    end
  end

endmodule

// File: tb/tb_cap_ctrl.sv
// Bench for cap_ctrl: per-frame gating scoreboard plus scenario tasks for
// frame counting, decimation, stop, geometry errors, watchdog and reset.
module tb_cap_ctrl;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int TO  = 100;
  localparam int NFW = 8;

  logic           pclk = 1'b0;
  logic           resetn = 1'b0;
  logic           FV = 1'b0;
  logic           LV = 1'b0;
  logic           cmd_start = 1'b0;
  logic           cmd_stop = 1'b0;
  logic [NFW-1:0] cfg_nframes = '0;
  logic [NFW-1:0] cfg_skip = '0;
  logic           cap_en, busy, done, err_size, err_timeout;
  logic [NFW-1:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  bit gate_q[$];
  bit mon_on = 1'b0;
  bit cur_exp = 1'b0;
  bit in_frame = 1'b0;
  bit fv_prev = 1'b0;
  int bad = 0;
  int frame_idx = 0;
  int done_cnt = 0;

  cap_ctrl #(.WIDTH(W), .HEIGTH(H), .TIMEOUT_CYC(TO), .NF_W(NFW)) dut (
    .pclk        (pclk),
    .resetn      (resetn),
    .FV          (FV),
    .LV          (LV),
    .cmd_start   (cmd_start),
    .cmd_stop    (cmd_stop),
    .cfg_nframes (cfg_nframes),
    .cfg_skip    (cfg_skip),
    .cap_en      (cap_en),
    .busy        (busy),
    .done        (done),
    .frame_cnt   (frame_cnt),
    .err_size    (err_size),
    .err_timeout (err_timeout)
  );

  always #5 pclk = ~pclk;

  // Gating scoreboard: each driven frame queues whether it must be captured.
  always @(negedge pclk) begin
    if (mon_on) begin
      if (FV && !fv_prev) begin
        in_frame = 1'b1;
        if (gate_q.size() == 0) begin
          checks++; errors++; cur_exp = 1'b0;
          $display("[TB] FAIL gate_queue_empty: frame %0d started with no expectation queued", frame_idx);
        end else begin
          cur_exp = gate_q.pop_front();
        end
      end
      if (FV) begin
        if (cap_en !== cur_exp) bad++;
      end else if (cap_en !== 1'b0) begin
        bad++;
      end
      if (!FV && fv_prev && in_frame) begin
        checks++;
        if (bad != 0) begin
          errors++;
          $display("[TB] FAIL gate_frame%0d: cap_en wrong in %0d cycles, required %0b while FV high and 0 otherwise", frame_idx, bad, cur_exp);
        end
        bad = 0; in_frame = 1'b0; frame_idx++;
      end
    end
    fv_prev = FV;
  end

  always @(negedge pclk) if (done === 1'b1) done_cnt++;

  task automatic tick;
    @(posedge pclk); #1;
  endtask

  task automatic pulse(input bit s, input bit p);
    cmd_start = s; cmd_stop = p;
    tick;
    cmd_start = 1'b0; cmd_stop = 1'b0;
  endtask

  task automatic drive_frame(input int nlines, input int short_ln, input bit exp);
    if (mon_on) gate_q.push_back(exp);
    FV = 1'b1; LV = 1'b0;
    tick; tick;
    for (int l = 0; l < nlines; l++) begin
      LV = 1'b1;
      repeat ((l == short_ln) ? W - 1 : W) tick;
      LV = 1'b0;
      tick; tick;
    end
    FV = 1'b0;
    repeat (4) tick;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick; tick;
    checks++; if (cap_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_cap_en: got %0b want 0", cap_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b want 0", done); end
    checks++; if ({err_size, err_timeout, frame_cnt} !== '0) begin errors++; $display("[TB] FAIL reset_status: got size=%0b to=%0b cnt=%0d want all 0", err_size, err_timeout, frame_cnt); end
    resetn = 1'b1;
    tick;
  endtask

  task automatic test_nframes;
    int d0;
    mon_on = 1'b1; bad = 0; d0 = done_cnt;
    cfg_nframes = 8'd2; cfg_skip = 8'd0;
    fork
      drive_frame(H, -1, 1'b0);
      begin
        repeat (10) tick;
        pulse(1'b1, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL nf_arm_busy: got %0b want 1", busy); end
      end
    join
    cfg_nframes = 8'd5;
    drive_frame(H, -1, 1'b1);
    drive_frame(H, -1, 1'b1);
    drive_frame(H, -1, 1'b0);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL nf_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("[TB] FAIL nf_frame_cnt: got %0d want 2", frame_cnt); end
    checks++; if (err_size !== 1'b0) begin errors++; $display("[TB] FAIL nf_err_size: got %0b want 0", err_size); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nf_busy_end: got %0b want 0", busy); end
  endtask

  task automatic test_skip;
    int d0;
    d0 = done_cnt;
    cfg_nframes = 8'd3; cfg_skip = 8'd1;
    pulse(1'b1, 1'b0);
    tick;
    for (int f = 0; f < 6; f++) drive_frame(H, -1, (f % 2) == 0);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL skip_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (frame_cnt !== 8'd3) begin errors++; $display("[TB] FAIL skip_frame_cnt: got %0d want 3", frame_cnt); end
  endtask

  task automatic test_stop;
    int d0;
    d0 = done_cnt;
    cfg_nframes = 8'd0; cfg_skip = 8'd0;
    pulse(1'b1, 1'b0);
    tick;
    repeat (3) drive_frame(H, -1, 1'b1);
    fork
      drive_frame(H, -1, 1'b1);
      begin repeat (20) tick; pulse(1'b0, 1'b1); end
    join
    drive_frame(H, -1, 1'b0);
    checks++; if (frame_cnt !== 8'd4) begin errors++; $display("[TB] FAIL stop_frame_cnt: got %0d want 4", frame_cnt); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("[TB] FAIL stop_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stop_busy: got %0b want 0", busy); end
  endtask

  task automatic test_geometry;
    cfg_nframes = 8'd0; cfg_skip = 8'd0;
    pulse(1'b1, 1'b0);
    tick;
    drive_frame(H, -1, 1'b1);
    checks++; if (err_size !== 1'b0) begin errors++; $display("[TB] FAIL geom_good_frame: got %0b want 0", err_size); end
    drive_frame(H, 1, 1'b1);
    checks++; if (err_size !== 1'b1) begin errors++; $display("[TB] FAIL geom_short_line: got %0b want 1", err_size); end
    drive_frame(H, -1, 1'b1);
    checks++; if ({busy, frame_cnt} !== {1'b1, 8'd3}) begin errors++; $display("[TB] FAIL geom_continues: got busy=%0b cnt=%0d want busy=1 cnt=3", busy, frame_cnt); end
    pulse(1'b0, 1'b1);
    tick;
    pulse(1'b1, 1'b0);
    checks++; if (err_size !== 1'b0) begin errors++; $display("[TB] FAIL geom_cleared_by_start: got %0b want 0", err_size); end
    tick;
    drive_frame(H - 1, -1, 1'b1);
    checks++; if (err_size !== 1'b1) begin errors++; $display("[TB] FAIL geom_short_frame: got %0b want 1", err_size); end
    pulse(1'b0, 1'b1);
    tick;
  endtask

  task automatic test_timeout;
    cfg_nframes = 8'd0; cfg_skip = 8'd0;
    pulse(1'b1, 1'b0);
    repeat (TO) tick;
    checks++; if ({busy, err_timeout} !== 2'b10) begin errors++; $display("[TB] FAIL to_before_expiry: got busy=%0b to=%0b want busy=1 to=0", busy, err_timeout); end
    tick;
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_flag: got %0b want 1", err_timeout); end
    checks++; if ({busy, cap_en} !== 2'b00) begin errors++; $display("[TB] FAIL to_error_state: got busy=%0b cap_en=%0b want 0 0", busy, cap_en); end
    pulse(1'b1, 1'b0);
    checks++; if ({busy, err_timeout} !== 2'b10) begin errors++; $display("[TB] FAIL to_recover: got busy=%0b to=%0b want busy=1 to=0", busy, err_timeout); end
    pulse(1'b0, 1'b1);
    tick;
  endtask

  task automatic test_reset_mid_frame;
    bit en_seen;
    mon_on = 1'b0;
    cfg_nframes = 8'd0; cfg_skip = 8'd0;
    pulse(1'b1, 1'b0);
    tick;
    drive_frame(H, 0, 1'b1);
    checks++; if ({err_size, frame_cnt} !== {1'b1, 8'd1}) begin errors++; $display("[TB] FAIL rst_precond: got size=%0b cnt=%0d want 1 1", err_size, frame_cnt); end
    fork
      drive_frame(H, -1, 1'b0);
      begin
        repeat (15) tick;
        checks++; if (cap_en !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_capture: got %0b want 1", cap_en); end
        resetn = 1'b0;
        #1;
        checks++; if ({cap_en, busy, done, err_size, err_timeout, frame_cnt} !== '0) begin errors++; $display("[TB] FAIL rst_async_values: got en=%0b busy=%0b done=%0b size=%0b to=%0b cnt=%0d want all 0", cap_en, busy, done, err_size, err_timeout, frame_cnt); end
        tick;
        resetn = 1'b1;
        en_seen = 1'b0;
        repeat (20) begin tick; if (cap_en !== 1'b0) en_seen = 1'b1; end
        checks++; if (en_seen !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_cap_en_after: got %0b want 0", en_seen); end
      end
    join
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle: got busy=%0b want 0", busy); end
  endtask

  task automatic test_start_stop_same;
    int d0;
    mon_on = 1'b1; bad = 0; d0 = done_cnt;
    pulse(1'b1, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ss_busy: got %0b want 0", busy); end
    tick;
    drive_frame(H, -1, 1'b0);
    checks++; if ({done_cnt - d0, busy} !== {32'd0, 1'b0}) begin errors++; $display("[TB] FAIL ss_no_job: got done=%0d busy=%0b want 0 0", done_cnt - d0, busy); end
  endtask

  initial begin
    test_reset;
    test_nframes;
    test_skip;
    test_stop;
    test_geometry;
    test_timeout;
    test_reset_mid_frame;
    test_start_stop_same;
    checks++;
    if (gate_q.size() != 0) begin errors++; $display("[TB] FAIL gate_queue_leftover: got %0d entries want 0", gate_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL global_timeout: simulation did not complete, got no finish want finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] stopped by time limit");
  end

endmodule
